// File: rtl/orb_pkg.sv
`default_nettype none
// ============================================================================
// orb_pkg : shared constants and state type for the orbital frame reader
// Rev 1.0 : initial release
// ============================================================================
package orb_pkg;

  localparam int WORD_W      = 12;
  localparam int ADDR_W      = 11;
  localparam int FRAME_WORDS = 2048;
  localparam int CLK_DIV     = 16;
  localparam int RD_LAT      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SEND  = 2'd2
  } orb_state_e;

endpackage
`default_nettype wire

// File: rtl/orb_bit_shifter.sv
`default_nettype none
// ============================================================================
// orb_bit_shifter : bit-rate divider, word shifter and bit counter (MSB first)
// Rev 1.0 : initial release
// ============================================================================
module orb_bit_shifter
  import orb_pkg::*;
#(
  parameter int WORD_W  = orb_pkg::WORD_W,
  parameter int CLK_DIV = orb_pkg::CLK_DIV,
  parameter int RD_LAT  = orb_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_load_data,
  output logic              o_bit_stb,
  output logic              o_ser,
  output logic              o_word_done,
  output logic              o_first_stb,
  output logic              o_hold_stb
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(WORD_W);

  logic              r_run;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic [WORD_W-1:0] r_sh;
  logic              w_div_last;
  logic              w_first_bit;

  assign w_div_last  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_first_bit = (r_bit == BIT_W'(WORD_W - 1));

  assign o_bit_stb   = r_run && (r_div == '0);
  assign o_ser       = r_run && r_sh[r_bit];
  assign o_word_done = r_run && w_div_last && (r_bit == '0);
  assign o_first_stb = o_bit_stb && w_first_bit;
  // Read data for the next word is valid RD_LAT cycles after the address
  // register updates, which happens on the cycle after the word's first strobe.
  assign o_hold_stb  = r_run && w_first_bit && (r_div == DIV_W'(RD_LAT + 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run <= 1'b0;
      r_div <= '0;
      r_bit <= '0;
      r_sh  <= '0;
    end else if (i_load) begin
      r_run <= 1'b1;
      r_div <= '0;
      r_bit <= BIT_W'(WORD_W - 1);
      r_sh  <= i_load_data;
    end else if (r_run) begin
      if (w_div_last) begin
        r_div <= '0;
        if (r_bit == '0) begin
          r_run <= 1'b0;
        end else begin
          r_bit <= r_bit - BIT_W'(1);
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/orb_frame_reader.sv
`default_nettype none
// ============================================================================
// orb_frame_reader : ping-pong frame RAM reader and telemetry serialiser
// Rev 1.0 : initial release
// ============================================================================
module orb_frame_reader
  import orb_pkg::*;
#(
  parameter int WORD_W      = orb_pkg::WORD_W,
  parameter int ADDR_W      = orb_pkg::ADDR_W,
  parameter int FRAME_WORDS = orb_pkg::FRAME_WORDS,
  parameter int CLK_DIV     = orb_pkg::CLK_DIV,
  parameter int RD_LAT      = orb_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] RdData,
  output logic [ADDR_W-1:0] RdAddr,
  output logic              RdBank,
  output logic              SW,
  output logic              orbSer,
  output logic              bitStb,
  output logic              frameStart,
  output logic              busy
);

  localparam int LAT_W = $clog2(RD_LAT + 2);
  localparam logic [ADDR_W:0] c_last_word   = (ADDR_W + 1)'(FRAME_WORDS - 1);
  localparam logic [ADDR_W:0] c_frame_words = (ADDR_W + 1)'(FRAME_WORDS);

  orb_state_e        r_state;
  orb_state_e        w_state_nxt;
  logic [LAT_W-1:0]  r_lat;
  logic [ADDR_W:0]   r_word;
  logic [ADDR_W:0]   w_word_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_bank;
  logic              r_sw;
  logic [WORD_W-1:0] r_hold;
  logic              w_load;
  logic [WORD_W-1:0] w_load_data;
  logic              w_frame_end;
  logic              w_bit_stb;
  logic              w_ser;
  logic              w_word_done;
  logic              w_first_stb;
  logic              w_hold_stb;

  assign w_word_nxt = r_word + (ADDR_W + 1)'(1);

  orb_bit_shifter #(
    .WORD_W  (WORD_W),
    .CLK_DIV (CLK_DIV),
    .RD_LAT  (RD_LAT)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .o_bit_stb   (w_bit_stb),
    .o_ser       (w_ser),
    .o_word_done (w_word_done),
    .o_first_stb (w_first_stb),
    .o_hold_stb  (w_hold_stb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_data = r_hold;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = PRIME;
        end
      end
      PRIME: begin
        if (r_lat == LAT_W'(RD_LAT)) begin
          w_load      = 1'b1;
          w_load_data = RdData;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_word_done) begin
          if (r_word == c_last_word) begin
            w_frame_end = 1'b1;
            w_state_nxt = en ? PRIME : IDLE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat  <= '0;
      r_word <= '0;
      r_addr <= '0;
      r_bank <= 1'b0;
      r_sw   <= 1'b1;
      r_hold <= '0;
    end else begin
      r_lat <= (r_state == PRIME) ? r_lat + LAT_W'(1) : '0;
      if (w_hold_stb) begin
        r_hold <= RdData;
      end
      // The swap cycle: new bank and address 0 take effect together.
      if (w_frame_end) begin
        r_word <= '0;
        r_addr <= '0;
        r_bank <= ~r_bank;
        r_sw   <= ~r_sw;
      end else begin
        if ((r_state == SEND) && w_word_done) begin
          r_word <= w_word_nxt;
        end
        if ((r_state == SEND) && w_first_stb && (w_word_nxt < c_frame_words)) begin
          r_addr <= w_word_nxt[ADDR_W-1:0];
        end
      end
    end
  end

  assign RdAddr     = r_addr;
  assign RdBank     = r_bank;
  assign SW         = r_sw;
  assign orbSer     = w_ser;
  assign bitStb     = w_bit_stb;
  assign frameStart = (r_state == SEND) && w_first_stb && (r_word == '0);
  assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_orb_frame_reader.sv
`default_nettype none
// ============================================================================
// tb_orb_frame_reader : randomized self-checking bench for orb_frame_reader
// Rev 1.0 : initial release
// ============================================================================
module tb_orb_frame_reader;

  localparam int WW    = 12;
  localparam int LAT   = 2;
  localparam int A_FW  = 4;
  localparam int A_AW  = 11;
  localparam int A_DIV = 4;
  localparam int B_FW  = 64;
  localparam int B_AW  = 6;
  localparam int B_DIV = 4;
  localparam int TMO   = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic            a_en, a_bank, a_sw, a_ser, a_stb, a_fs, a_busy;
  logic [WW-1:0]   a_rdata, a_p0, a_p1;
  logic [A_AW-1:0] a_addr;
  logic [WW-1:0]   mem_a [0:1][0:A_FW-1];

  logic            b_en, b_bank, b_sw, b_ser, b_stb, b_fs, b_busy;
  logic [WW-1:0]   b_rdata, b_p0, b_p1;
  logic [B_AW-1:0] b_addr;
  logic [WW-1:0]   mem_b [0:1][0:B_FW-1];

  int fs_cnt_a = 0;
  int addr_q[$];

  // Two-stage read pipeline gives the RAM its read latency.
  always @(posedge clk) begin
    a_p0 <= mem_a[a_bank][a_addr[1:0]];
    a_p1 <= a_p0;
    b_p0 <= mem_b[b_bank][b_addr];
    b_p1 <= b_p0;
  end
  assign a_rdata = a_p1;
  assign b_rdata = b_p1;

  always @(negedge clk) if (a_fs === 1'b1) fs_cnt_a <= fs_cnt_a + 1;

  orb_frame_reader #(.WORD_W(WW), .ADDR_W(A_AW), .FRAME_WORDS(A_FW), .CLK_DIV(A_DIV), .RD_LAT(LAT)) u_dut_a (
    .clk(clk), .rst(rst), .en(a_en), .RdData(a_rdata), .RdAddr(a_addr), .RdBank(a_bank),
    .SW(a_sw), .orbSer(a_ser), .bitStb(a_stb), .frameStart(a_fs), .busy(a_busy)
  );

  orb_frame_reader #(.WORD_W(WW), .ADDR_W(B_AW), .FRAME_WORDS(B_FW), .CLK_DIV(B_DIV), .RD_LAT(LAT)) u_dut_b (
    .clk(clk), .rst(rst), .en(b_en), .RdData(b_rdata), .RdAddr(b_addr), .RdBank(b_bank),
    .SW(b_sw), .orbSer(b_ser), .bitStb(b_stb), .frameStart(b_fs), .busy(b_busy)
  );

  // Reference: a frame is the bank's words concatenated, sent MSB first.
  function automatic logic [A_FW*WW-1:0] exp_a(input int bank);
    logic [A_FW*WW-1:0] v;
    v = '0;
    for (int w = 0; w < A_FW; w++) v = {v[(A_FW-1)*WW-1:0], mem_a[bank][w]};
    return v;
  endfunction

  function automatic logic exp_b_bit(input int bank, input int idx);
    logic [WW-1:0] w;
    w = mem_b[bank][idx / WW];
    return w[WW - 1 - (idx % WW)];
  endfunction

  // Waits for frameStart, then records one full frame of DUT A and counts
  // timing deviations (strobe placement, bit hold, busy, SW polarity).
  task automatic capture_a(input int drop_k, output int wait_cnt,
                           output logic [A_FW*WW-1:0] bits, output int terr);
    int nb;
    logic [A_AW-1:0] last_addr;
    nb = A_FW * WW;
    wait_cnt = 0; terr = 0; bits = '0;
    addr_q.delete();
    do begin
      @(negedge clk);
      wait_cnt++;
    end while (a_fs !== 1'b1 && wait_cnt < TMO);
    if (a_fs !== 1'b1) begin
      wait_cnt = -1;
      return;
    end
    last_addr = a_addr;
    addr_q.push_back(int'(a_addr));
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < A_DIV; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        if (k == drop_k && j == 0) a_en = 1'b0;
        if (a_stb !== (j == 0)) terr++;
        if (a_fs !== (k == 0 && j == 0)) terr++;
        if (a_busy !== 1'b1) terr++;
        if (a_sw !== ~a_bank) terr++;
        if (j == 0) bits[nb-1-k] = a_ser;
        else if (a_ser !== bits[nb-1-k]) terr++;
        if (a_addr != last_addr) begin
          addr_q.push_back(int'(a_addr));
          last_addr = a_addr;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; a_en = 1'b0; b_en = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (a_addr !== '0)   begin fails++; $display("FAIL reset_rdaddr got %0h want 0", a_addr); end
    tests++; if (a_bank !== 1'b0) begin fails++; $display("FAIL reset_rdbank got %b want 0", a_bank); end
    tests++; if (a_sw !== 1'b1)   begin fails++; $display("FAIL reset_sw got %b want 1", a_sw); end
    tests++; if (a_ser !== 1'b0)  begin fails++; $display("FAIL reset_orbser got %b want 0", a_ser); end
    tests++; if (a_stb !== 1'b0)  begin fails++; $display("FAIL reset_bitstb got %b want 0", a_stb); end
    tests++; if (a_fs !== 1'b0)   begin fails++; $display("FAIL reset_framestart got %b want 0", a_fs); end
    tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", a_busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL idle_without_en busy got %b want 0", a_busy); end
  endtask

  task automatic test_first_frame();
    int wc, terr, bad;
    logic [A_FW*WW-1:0] bits, exp;
    logic [WW-1:0] w0;
    mem_a[0][0] = 12'h5A8;
    a_en = 1'b1;
    capture_a(-1, wc, bits, terr);
    exp = exp_a(0);
    w0 = bits[A_FW*WW-1 -: WW];
    tests++; if (wc !== LAT + 2) begin fails++; $display("FAIL first_latency got %0d want %0d", wc, LAT + 2); end
    tests++; if (w0 !== 12'h5A8) begin fails++; $display("FAIL first_word got %h want 5a8", w0); end
    tests++; if (bits !== exp) begin fails++; $display("FAIL frame0_bits got %h want %h", bits, exp); end
    tests++; if (terr !== 0) begin fails++; $display("FAIL frame0_timing got %0d errors want 0", terr); end
    bad = (addr_q.size() != A_FW) ? 1 : 0;
    foreach (addr_q[i]) if (addr_q[i] != i) bad = 1;
    tests++; if (bad !== 0) begin fails++; $display("FAIL rdaddr_seq got %p want 0..%0d", addr_q, A_FW - 1); end
    tests++; if (a_bank !== 1'b0 || a_sw !== 1'b1) begin fails++; $display("FAIL pre_swap bank/sw got %b/%b want 0/1", a_bank, a_sw); end
    @(negedge clk);
    tests++; if (a_bank !== 1'b1 || a_sw !== 1'b0 || a_addr !== '0) begin
      fails++; $display("FAIL swap bank/sw/addr got %b/%b/%0h want 1/0/0", a_bank, a_sw, a_addr);
    end
  endtask

  task automatic test_back_to_back();
    int wc, terr;
    logic [A_FW*WW-1:0] bits, exp;
    mem_a[0][0] = 12'h001; mem_a[0][1] = 12'h800; mem_a[0][2] = 12'hFFF; mem_a[0][3] = 12'h000;
    capture_a(-1, wc, bits, terr);
    exp = exp_a(1);
    tests++; if (wc !== LAT + 1) begin fails++; $display("FAIL frame1_gap got %0d want %0d", wc, LAT + 1); end
    tests++; if (bits !== exp) begin fails++; $display("FAIL frame1_bank1_bits got %h want %h", bits, exp); end
    tests++; if (terr !== 0) begin fails++; $display("FAIL frame1_timing got %0d errors want 0", terr); end
    @(negedge clk);
    tests++; if (a_bank !== 1'b0 || a_sw !== 1'b1) begin fails++; $display("FAIL swap2 bank/sw got %b/%b want 0/1", a_bank, a_sw); end
  endtask

  task automatic test_en_drop();
    int wc, terr, base, idle_err;
    logic [A_FW*WW-1:0] bits, exp;
    base = fs_cnt_a;
    capture_a(WW * 2, wc, bits, terr);
    exp = exp_a(0);
    tests++; if (wc !== LAT + 1) begin fails++; $display("FAIL frame2_gap got %0d want %0d", wc, LAT + 1); end
    tests++; if (bits !== exp) begin fails++; $display("FAIL frame2_bits got %h want %h", bits, exp); end
    tests++; if (terr !== 0) begin fails++; $display("FAIL frame2_timing_after_en_drop got %0d errors want 0", terr); end
    @(negedge clk);
    tests++; if (a_busy !== 1'b0 || a_ser !== 1'b0 || a_bank !== 1'b1) begin
      fails++; $display("FAIL idle_after_drop busy/ser/bank got %b/%b/%b want 0/0/1", a_busy, a_ser, a_bank);
    end
    idle_err = 0;
    repeat (300) begin
      @(negedge clk);
      if (a_fs !== 1'b0 || a_busy !== 1'b0 || a_ser !== 1'b0) idle_err++;
    end
    tests++; if (idle_err !== 0) begin fails++; $display("FAIL stays_idle got %0d bad cycles want 0", idle_err); end
    tests++; if (fs_cnt_a - base !== 1) begin fails++; $display("FAIL framestart_count got %0d want 1", fs_cnt_a - base); end
  endtask

  task automatic test_reset_mid();
    int n, wc, terr;
    logic [A_FW*WW-1:0] bits, exp;
    a_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (a_fs !== 1'b1 && n < TMO);
    tests++; if (a_fs !== 1'b1 || a_bank !== 1'b1) begin fails++; $display("FAIL mid_frame_start fs/bank got %b/%b want 1/1", a_fs, a_bank); end
    repeat (2 * WW * A_DIV + 1) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (a_ser !== 1'b0 || a_stb !== 1'b0 || a_fs !== 1'b0 || a_busy !== 1'b0 ||
                 a_addr !== '0 || a_bank !== 1'b0 || a_sw !== 1'b1) begin
      fails++; $display("FAIL async_reset ser/stb/fs/busy/addr/bank/sw got %b/%b/%b/%b/%0h/%b/%b want 0/0/0/0/0/0/1",
                        a_ser, a_stb, a_fs, a_busy, a_addr, a_bank, a_sw);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    capture_a(0, wc, bits, terr);
    exp = exp_a(0);
    tests++; if (wc !== LAT + 2) begin fails++; $display("FAIL restart_latency got %0d want %0d", wc, LAT + 2); end
    tests++; if (bits !== exp) begin fails++; $display("FAIL restart_bank0_bits got %h want %h", bits, exp); end
    tests++; if (terr !== 0) begin fails++; $display("FAIL restart_timing got %0d errors want 0", terr); end
  endtask

  task automatic test_full_bank();
    int n, stb, berr, max_addr, wrap_err, swap_ok, got2;
    logic [B_AW-1:0] last_addr;
    logic last_bank;
    b_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (b_fs !== 1'b1 && n < TMO);
    tests++; if (b_fs !== 1'b1) begin fails++; $display("FAIL full_bank_start got %b want 1", b_fs); end
    stb = 1; berr = 0; max_addr = 0; wrap_err = 0; swap_ok = 0; got2 = 0;
    if (b_ser !== exp_b_bit(0, 0)) berr++;
    last_addr = b_addr; last_bank = b_bank;
    for (int t = 0; t < B_FW * WW * B_DIV + 50; t++) begin
      @(negedge clk);
      if (b_fs === 1'b1) begin
        got2 = 1;
        break;
      end
      if (b_stb === 1'b1) begin
        if (stb < B_FW * WW && b_ser !== exp_b_bit(0, stb)) berr++;
        stb++;
      end
      if (int'(b_addr) > max_addr) max_addr = int'(b_addr);
      if (b_addr != last_addr && b_addr == '0 && b_bank == last_bank) wrap_err++;
      if (b_bank != last_bank && int'(last_addr) == B_FW - 1 && b_addr == '0) swap_ok = 1;
      last_addr = b_addr; last_bank = b_bank;
    end
    b_en = 1'b0;
    tests++; if (got2 !== 1) begin fails++; $display("FAIL full_bank_second_start got %0d want 1", got2); end
    tests++; if (stb !== B_FW * WW) begin fails++; $display("FAIL full_bank_bitstb_count got %0d want %0d", stb, B_FW * WW); end
    tests++; if (berr !== 0) begin fails++; $display("FAIL full_bank_bits got %0d errors want 0", berr); end
    tests++; if (max_addr !== B_FW - 1) begin fails++; $display("FAIL full_bank_max_addr got %0d want %0d", max_addr, B_FW - 1); end
    tests++; if (wrap_err !== 0 || swap_ok !== 1) begin
      fails++; $display("FAIL full_bank_wrap early_wraps %0d swap_wrap %0d want 0 and 1", wrap_err, swap_ok);
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < A_FW; i++) mem_a[b][i] = WW'($urandom);
      for (int i = 0; i < B_FW; i++) mem_b[b][i] = WW'($urandom);
    end
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_full_bank();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
